// File: rtl/jk_bank_arbiter.sv
// ----------------------------------------------------------------------------
// jk_bank_arbiter
//
// Four requesters share one WIDTH-bit bank of JK flip-flops. Each cycle a
// round-robin arbiter picks at most one requester. The winner's J/K vectors
// are applied to the bank on the same edge that raises its grant. A
// requester that has just been granted is masked for the next cycle, so a
// requester that keeps REQ high is granted at most every second cycle.
//
// Ports
//   CLK   in   1          clock; all state updates on the rising edge
//   RST   in   1          synchronous, active-high reset
//   REQ   in   4          request, bit i belongs to requester i
//   J     in   4*WIDTH    J vectors, requester i owns [i*WIDTH +: WIDTH]
//   K     in   4*WIDTH    K vectors, same slicing as J
//   GNT   out  4          registered one-hot grant pulse
//   Q     out  WIDTH      registered bank state
//   notQ  out  WIDTH      combinational complement of Q
//   BUSY  out  1          registered, high whenever GNT is nonzero
// ----------------------------------------------------------------------------
module jk_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [3:0]         REQ,
  input  logic [4*WIDTH-1:0] J,
  input  logic [4*WIDTH-1:0] K,
  output logic [3:0]         GNT,
  output logic [WIDTH-1:0]   Q,
  output logic [WIDTH-1:0]   notQ,
  output logic               BUSY
);

  // The requester count is structural (port widths, pointer width), so it
  // is a localparam rather than an overridable parameter.
  localparam int NREQ = 4;

  logic [WIDTH-1:0] q_q,    q_d;
  logic [3:0]       gnt_q,  gnt_d;
  logic             busy_q, busy_d;
  logic [1:0]       ptr_q,  ptr_d;
  logic [3:0]       mask_q, mask_d;

  logic [3:0]       eligible;
  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic [WIDTH-1:0] j_win;
  logic [WIDTH-1:0] k_win;

  // Round-robin search starting at the pointer; first eligible index wins.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    eligible  = REQ & ~mask_q;
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_q + 2'(k);   // wraps mod 4 by width
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state logic for the bank, grant, pointer and mask.
  always_comb begin
    j_win  = J[int'(win_idx)*WIDTH +: WIDTH];
    k_win  = K[int'(win_idx)*WIDTH +: WIDTH];
    q_d    = q_q;
    gnt_d  = 4'b0000;
    busy_d = 1'b0;
    ptr_d  = ptr_q;
    mask_d = 4'b0000;
    if (win_found) begin
      // JK characteristic equation: Q+ = J&~Q | ~K&Q, bitwise.
      q_d    = (j_win & ~q_q) | (~k_win & q_q);
      gnt_d  = 4'b0001 << win_idx;
      busy_d = 1'b1;
      ptr_d  = win_idx + 2'd1;
      mask_d = 4'b0001 << win_idx;
    end
  end

  // Reset wins over any grant in the same cycle; nothing is remembered.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      q_q    <= '0;
      gnt_q  <= 4'b0000;
      busy_q <= 1'b0;
      ptr_q  <= 2'd0;
      mask_q <= 4'b0000;
    end else begin
      q_q    <= q_d;
      gnt_q  <= gnt_d;
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
      mask_q <= mask_d;
    end
  end

  assign GNT  = gnt_q;
  assign Q    = q_q;
  assign notQ = ~q_q;
  assign BUSY = busy_q;

endmodule
